// File: rtl/vga_mon_pkg.sv
// vga_mon_pkg: default 640x480@60 geometry and the frame-monitor state encoding.
package vga_mon_pkg;
  localparam int DEF_ACT_W   = 640;
  localparam int DEF_ACT_H   = 480;
  localparam int DEF_H_TOTAL = 800;
  localparam int DEF_V_TOTAL = 525;
  localparam int DEF_CW      = 8;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    FRAME     = 1'b1
  } state_t;
endpackage

// File: rtl/vga_mon_if.sv
// vga_mon_if: VGA pixel stream (syncs, pixel strobe, active flag, colour).
interface vga_mon_if
  import vga_mon_pkg::*;
#(
  parameter int CW = DEF_CW
);
  logic          hsync;
  logic          vsync;
  logic          ptick;
  logic          von;
  logic [CW-1:0] rgb;

  modport master (output hsync, vsync, ptick, von, rgb);
  modport slave  (input  hsync, vsync, ptick, von, rgb);
endinterface

// File: rtl/vga_mon_linebuf.sv
// vga_mon_linebuf: 1024 x CW simple dual-port line buffer with registered read;
// a read and a write to the same address in one cycle return the old word.
module vga_mon_linebuf
  import vga_mon_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [9:0]    waddr,
  input  logic [CW-1:0] wdata,
  input  logic [9:0]    raddr,
  output logic [CW-1:0] rdata
);
  logic [CW-1:0] mem [0:1023];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
  end
endmodule

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: rebuilds pixel coordinates from a VGA sync stream, measures
// line/frame timing, checksums each frame and captures one selected line.
module vga_frame_monitor
  import vga_mon_pkg::*;
#(
  parameter int ACT_W    = DEF_ACT_W,
  parameter int ACT_H    = DEF_ACT_H,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int SYNC_POL = 1,
  parameter int CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  vga_mon_if.slave      vga,
  input  logic [9:0]    cap_line,
  input  logic [9:0]    rd_addr,
  output logic [CW-1:0] rd_data,
  output logic [9:0]    cur_x,
  output logic [9:0]    cur_y,
  output logic          frame_done,
  output logic          frame_ok,
  output logic [15:0]   checksum,
  output logic [11:0]   h_meas,
  output logic [9:0]    v_meas,
  output logic          cap_valid
);
  localparam logic [9:0]  ACT_W_V = 10'(ACT_W);
  localparam logic [9:0]  ACT_H_V = 10'(ACT_H);
  localparam logic [11:0] H_TOT_V = 12'(H_TOTAL);
  localparam logic [9:0]  V_TOT_V = 10'(V_TOTAL);
  localparam logic        POL     = 1'(SYNC_POL);

  state_t      state, state_nx;
  logic        hs_q, vs_q, hs_lead, vs_lead, accept, f_start, f_close;
  logic [9:0]  x_cnt, y_cnt, v_cnt, cap_lat;
  logic [11:0] pt_cnt, pt_inc;
  logic [15:0] acc;
  logic        err, line_px, first_hs, cap_en, cap_we;

  logic [9:0]  x_px, y_hs, v_hs;
  logic [15:0] acc_px;
  logic        err_px, err_hs, line_px_px, cap_done;

  assign hs_lead = (vga.hsync == POL) && (hs_q != POL);
  assign vs_lead = (vga.vsync == POL) && (vs_q != POL);
  assign accept  = (state == FRAME) && vga.ptick && vga.von;
  assign pt_inc  = (pt_cnt == 12'hFFF) ? pt_cnt : pt_cnt + 12'd1;
  assign cap_en  = cap_lat < ACT_H_V;
  assign cap_we  = accept && cap_en && (y_cnt == cap_lat) && (x_cnt != ACT_W_V);

  // SYNC_WAIT | no frame reference yet, waiting for the first vsync leading edge
  // FRAME     | accepting pixels; every vsync leading edge closes and restarts a frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SYNC_WAIT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    f_start  = 1'b0;
    f_close  = 1'b0;
    case (state)
      SYNC_WAIT: if (vs_lead) begin
        state_nx = FRAME;
        f_start  = 1'b1;
      end
      FRAME: if (vs_lead) begin
        f_close = 1'b1;
        f_start = 1'b1;
      end
      default: state_nx = SYNC_WAIT;
    endcase
  end

  always_comb begin
    x_px       = x_cnt;
    err_px     = err;
    acc_px     = acc;
    line_px_px = line_px;
    if (accept) begin
      acc_px     = acc + 16'(vga.rgb);
      line_px_px = 1'b1;
      if (x_cnt == ACT_W_V) err_px = 1'b1;
      else                  x_px   = x_cnt + 10'd1;
    end
  end

  // Line close sees this cycle's pixel, so a coincident hsync lands in the closing frame.
  always_comb begin
    y_hs     = y_cnt;
    v_hs     = v_cnt;
    err_hs   = err_px;
    cap_done = 1'b0;
    if (hs_lead && (state == FRAME)) begin
      if (v_cnt != 10'h3FF) v_hs = v_cnt + 10'd1;
      if (!first_hs && (pt_cnt != H_TOT_V)) err_hs = 1'b1;
      if (line_px_px) begin
        if (y_cnt != 10'h3FF) y_hs = y_cnt + 10'd1;
        if (!first_hs && (x_px != ACT_W_V)) err_hs = 1'b1;
        if (cap_en && (y_cnt == cap_lat) && (x_px == ACT_W_V)) cap_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q       <= POL;
      vs_q       <= POL;
      x_cnt      <= '0;
      y_cnt      <= '0;
      v_cnt      <= '0;
      cap_lat    <= '0;
      pt_cnt     <= '0;
      acc        <= '0;
      err        <= 1'b0;
      line_px    <= 1'b0;
      first_hs   <= 1'b1;
      cur_x      <= '0;
      cur_y      <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      checksum   <= '0;
      h_meas     <= '0;
      v_meas     <= '0;
      cap_valid  <= 1'b0;
    end else begin
      hs_q       <= vga.hsync;
      vs_q       <= vga.vsync;
      frame_done <= f_close;
      if (accept) begin
        cur_x <= x_cnt;
        cur_y <= y_cnt;
      end
      if (hs_lead)        pt_cnt <= {11'd0, vga.ptick};
      else if (vga.ptick) pt_cnt <= pt_inc;
      if (state == FRAME) begin
        x_cnt   <= x_px;
        acc     <= acc_px;
        err     <= err_hs;
        y_cnt   <= y_hs;
        v_cnt   <= v_hs;
        line_px <= line_px_px;
        if (hs_lead) begin
          h_meas   <= pt_cnt;
          first_hs <= 1'b0;
          if (line_px_px) begin
            x_cnt   <= '0;
            line_px <= 1'b0;
          end
          if (cap_done) cap_valid <= 1'b1;
        end
      end
      if (f_close) begin
        checksum <= acc_px;
        v_meas   <= v_hs;
        frame_ok <= !err_hs && (y_hs == ACT_H_V) && (v_hs == V_TOT_V);
      end
      if (f_start) begin
        x_cnt     <= '0;
        y_cnt     <= '0;
        v_cnt     <= '0;
        acc       <= '0;
        err       <= 1'b0;
        line_px   <= 1'b0;
        first_hs  <= 1'b1;
        cap_valid <= 1'b0;
        cap_lat   <= cap_line;
      end
    end
  end

  vga_mon_linebuf #(.CW(CW)) u_linebuf (
    .clk   (clk),
    .reset (reset),
    .we    (cap_we),
    .waddr (x_cnt),
    .wdata (vga.rgb),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
endmodule
